// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC conversion scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_sched_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } adc_state_e;

  localparam int   ADC_MIN_PERIOD  = 3;
  localparam logic ADC_MODE_CONT   = 1'b0;
  localparam logic ADC_MODE_SINGLE = 1'b1;
endpackage

// File: rtl/adc_period_counter.sv
// Loadable up-counter: counts while enabled, wraps to 0 at the loaded limit and flags terminal count.
// Latency: tc_out is combinational from the count register; the limit loads on the next edge.
// Backpressure: none; the owner gates counting with count_in.
module adc_period_counter #(
  parameter int PERIOD_W = 8
) (
  input  logic                clock_in,
  input  logic                reset_in,
  input  logic                clear_in,
  input  logic                count_in,
  input  logic                load_in,
  input  logic [PERIOD_W-1:0] limit_in,
  output logic [PERIOD_W-1:0] cnt_out,
  output logic                tc_out
);
  import adc_sched_pkg::*;

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] limit_q;

  // The limit is reloaded while the count sits at 0, so terminal count is never taken there.
  assign tc_out  = count_in && (cnt_q != '0) && (cnt_q == limit_q);
  assign cnt_out = cnt_q;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      cnt_q   <= '0;
      limit_q <= PERIOD_W'(ADC_MIN_PERIOD);
    end else begin
      if (load_in) limit_q <= limit_in;
      if (clear_in || tc_out) cnt_q <= '0;
      else if (count_in)      cnt_q <= cnt_q + PERIOD_W'(1);
    end
  end
endmodule

// File: rtl/adc_sample_scheduler.sv
// ADC conversion timer: restart pulse, round-robin channel select, tagged sample strobe per conversion.
// Latency: all outputs registered; strobe one cycle after the last count. Optional ADC_SCHED_OVERRUN_EN adds
// Backpressure: none; with ADC_SCHED_OVERRUN_EN an unacknowledged sample hit by a new strobe sets sticky overrun.
module adc_sample_scheduler #(
  parameter  int PERIOD_W = 8,
  parameter  int NUM_CH   = 4,
  parameter  int RST_LOW  = 2,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clock_in,
  input  logic                reset_in,
  input  logic                enable_in,
  input  logic                mode_in,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                sample_ack_in,
  output logic                adc_reset_n,
  output logic [CH_W-1:0]     adc_ch_out,
  output logic                sample_strobe_out,
  output logic [CH_W-1:0]     sample_ch_out,
  output logic                scan_done_out,
  output logic                busy_out,
  output logic                overrun_out
);
  import adc_sched_pkg::*;

  adc_state_e          state_q;
  logic                mode_q;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_clamped;
  logic                tc;
  logic                last_ch;
  logic [CH_W-1:0]     ch_nxt;

  assign period_clamped = (period_in < PERIOD_W'(ADC_MIN_PERIOD)) ? PERIOD_W'(ADC_MIN_PERIOD) : period_in;
  assign last_ch        = (adc_ch_out == CH_W'(NUM_CH - 1));
  assign ch_nxt         = last_ch ? '0 : adc_ch_out + CH_W'(1);

  adc_period_counter #(.PERIOD_W(PERIOD_W)) u_period_counter (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .clear_in (state_q != CONV),
    .count_in (state_q == CONV),
    .load_in  ((state_q == CONV) && (cnt == '0)),
    .limit_in (period_clamped),
    .cnt_out  (cnt),
    .tc_out   (tc)
  );

  // Outputs are registered from the upcoming state/count, so the restart pulse and new channel
  // appear in the same cycle as the strobe for the conversion that just ended.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q           <= IDLE;
      mode_q            <= ADC_MODE_CONT;
      adc_reset_n       <= 1'b0;
      adc_ch_out        <= '0;
      sample_strobe_out <= 1'b0;
      sample_ch_out     <= '0;
      scan_done_out     <= 1'b0;
      busy_out          <= 1'b0;
    end else begin
      sample_strobe_out <= 1'b0;
      scan_done_out     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          adc_reset_n <= 1'b0;
          if (enable_in) begin
            state_q    <= CONV;
            mode_q     <= mode_in;
            adc_ch_out <= '0;
            busy_out   <= 1'b1;
          end else begin
            busy_out <= 1'b0;
          end
        end
        CONV: begin
          if (tc) begin
            sample_strobe_out <= 1'b1;
            sample_ch_out     <= adc_ch_out;
            scan_done_out     <= last_ch;
            adc_ch_out        <= ch_nxt;
            adc_reset_n       <= 1'b0;
            if (!enable_in) begin
              state_q  <= IDLE;
              busy_out <= 1'b0;
            end else if ((mode_q == ADC_MODE_SINGLE) && last_ch) begin
              state_q <= HOLD;
            end
          end else begin
            adc_reset_n <= (cnt >= PERIOD_W'(RST_LOW - 1));
          end
        end
        HOLD: begin
          adc_reset_n <= 1'b0;
          if (!enable_in) begin
            state_q  <= IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          adc_reset_n <= 1'b0;
          busy_out    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADC_SCHED_OVERRUN_EN
  logic pending_q;
  logic overrun_q;

  // An ack in a strobe cycle retires the previous sample; the new one is still outstanding.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (sample_strobe_out) begin
      pending_q <= 1'b1;
      if (pending_q && !sample_ack_in) overrun_q <= 1'b1;
    end else if (sample_ack_in) begin
      pending_q <= 1'b0;
    end
  end

  assign overrun_out = overrun_q;
`else
  logic unused_ack;
  assign unused_ack  = sample_ack_in;
  assign overrun_out = 1'b0;
`endif
endmodule
